// File: rtl/game_pkg.sv
// Shared constants, FSM state type and helpers for the enemy projectile blocks.
package game_pkg;
   localparam int NUM_SLOTS     = 5;
   localparam int SLOT_W        = 9;
   localparam int COORD_W       = 10;
   localparam int SCREEN_BOTTOM = 460;
   localparam int PARK_X        = 0;
   localparam logic [SLOT_W-1:0] PARK_Y = 9'd470;

   typedef enum logic {ALIVE, DEAD} enemy_state_e;

   // Ordered subtraction so the distance never wraps negative.
   function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction
endpackage

// File: rtl/proj_slot.sv
// One enemy projectile slot: launch when free, fall each tick, park on bottom or kill.
module proj_slot
   import game_pkg::*;
#(
   parameter int XW     = SLOT_W,
   parameter int STEP   = 1,
   parameter int BOTTOM = SCREEN_BOTTOM
) (
   input  logic              clk_4,
   input  logic              clr,
   input  logic              launch,
   input  logic [XW-1:0]     launch_x,
   input  logic [SLOT_W-1:0] launch_y,
   input  logic              kill,
   output logic              active,
   output logic [XW-1:0]     x,
   output logic [SLOT_W-1:0] y
);
   logic              active_q, active_d;
   logic [XW-1:0]     x_q, x_d;
   logic [SLOT_W-1:0] y_q, y_d, y_step;

   assign y_step = y_q + SLOT_W'(STEP);

   // Kill and launch only matter for the slot's state at the start of the tick.
   always_comb begin
      active_d = active_q;
      x_d      = x_q;
      y_d      = y_q;
      if (!active_q) begin
         if (launch) begin
            active_d = 1'b1;
            x_d      = launch_x;
            y_d      = launch_y;
         end
      end else if (kill || (y_step >= SLOT_W'(BOTTOM))) begin
         active_d = 1'b0;
         x_d      = XW'(PARK_X);
         y_d      = PARK_Y;
      end else begin
         y_d = y_step;
      end
   end

   always_ff @(posedge clk_4) begin
      if (clr) begin
         active_q <= 1'b0;
         x_q      <= XW'(PARK_X);
         y_q      <= PARK_Y;
      end else begin
         active_q <= active_d;
         x_q      <= x_d;
         y_q      <= y_d;
      end
   end

   assign active = active_q;
   assign x      = x_q;
   assign y      = y_q;
endmodule

// File: rtl/enemy_shooter.sv
// Per-enemy projectile manager: fire timer, lowest-free slot launch, hit detect and
// ALIVE/DEAD respawn FSM, with five proj_slot instances packed onto the outputs.
module enemy_shooter
   import game_pkg::*;
#(
   parameter int FIRE_PERIOD = 120,
   parameter int STEP        = 1,
   parameter int BOTTOM      = SCREEN_BOTTOM,
   parameter int SPAWN_DY    = 12,
   parameter int RESPAWN     = 240,
   parameter int HIT_HALF    = 10
) (
   input  logic        clk_4,
   input  logic        clr,
   input  logic        play,
   input  logic [9:0]  enemy_x,
   input  logic [9:0]  enemy_y,
   input  logic [4:0]  destroy,
   input  logic [9:0]  pproj_x,
   input  logic [9:0]  pproj_y,
   output logic [45:0] projectiles_x,
   output logic [44:0] projectiles_y,
   output logic        collide,
   output logic        alive,
   output logic        fire_evt
);
   localparam int TW = $clog2(FIRE_PERIOD + 1);
   localparam int CW = $clog2(RESPAWN + 1);

   enemy_state_e         state_q;
   logic [TW-1:0]        timer_q;
   logic [CW-1:0]        cnt_q;
   logic                 collide_q, alive_q, fire_evt_q;
   logic                 srst, hit, fire_ok;
   logic [NUM_SLOTS-1:0] active, free, grant, launch;
   logic [SLOT_W-1:0]    spawn_y;

   assign srst    = clr | ~play;
   assign spawn_y = enemy_y[SLOT_W-1:0] + SLOT_W'(SPAWN_DY);

   // Lowest set bit of the free mask, taken from slot state before this tick's updates.
   assign free  = ~active;
   assign grant = free & (~free + NUM_SLOTS'(1));

   assign hit = (state_q == ALIVE) &&
                (pproj_y < {1'b0, PARK_Y}) &&
                (abs_diff(pproj_x, enemy_x) < COORD_W'(HIT_HALF)) &&
                (abs_diff(pproj_y, enemy_y) < COORD_W'(HIT_HALF));

   // A hit wins over a coinciding fire attempt: the enemy dies instead of shooting.
   assign fire_ok = (state_q == ALIVE) && !hit &&
                    (timer_q == TW'(FIRE_PERIOD - 1)) && (|free);
   assign launch  = fire_ok ? grant : '0;

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      localparam int XW = (i == NUM_SLOTS - 1) ? COORD_W : SLOT_W;
      logic [XW-1:0] sx;
      proj_slot #(.XW(XW), .STEP(STEP), .BOTTOM(BOTTOM)) u_slot (
         .clk_4    (clk_4),
         .clr      (srst),
         .launch   (launch[i]),
         .launch_x (enemy_x[XW-1:0]),
         .launch_y (spawn_y),
         .kill     (destroy[i]),
         .active   (active[i]),
         .x        (sx),
         .y        (projectiles_y[SLOT_W*i +: SLOT_W])
      );
      assign projectiles_x[SLOT_W*i +: XW] = sx;
   end

   always_ff @(posedge clk_4) begin
      if (srst) begin
         state_q    <= ALIVE;
         timer_q    <= '0;
         cnt_q      <= '0;
         collide_q  <= 1'b0;
         alive_q    <= 1'b1;
         fire_evt_q <= 1'b0;
      end else begin
         collide_q  <= 1'b0;
         fire_evt_q <= 1'b0;
         case (state_q)
            ALIVE: begin
               if (hit) begin
                  collide_q <= 1'b1;
                  alive_q   <= 1'b0;
                  state_q   <= DEAD;
                  cnt_q     <= CW'(RESPAWN - 1);
                  timer_q   <= '0;
               end else begin
                  timer_q    <= (timer_q == TW'(FIRE_PERIOD - 1)) ? '0 : timer_q + TW'(1);
                  fire_evt_q <= fire_ok;
               end
            end
            DEAD: begin
               if (cnt_q == '0) begin
                  state_q <= ALIVE;
                  alive_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= ALIVE;
         endcase
      end
   end

   assign collide  = collide_q;
   assign alive    = alive_q;
   assign fire_evt = fire_evt_q;
endmodule

// File: tb/tb_enemy_shooter.sv
// Directed bench for enemy_shooter with FIRE_PERIOD=4 and RESPAWN=8.
module tb_enemy_shooter;
   logic        clk_4 = 1'b0;
   logic        clr = 1'b0, play = 1'b1;
   logic [9:0]  enemy_x = 10'd300, enemy_y = 10'd100;
   logic [9:0]  pproj_x = 10'd0, pproj_y = 10'd470;
   logic [4:0]  destroy = 5'b0;
   logic [45:0] projectiles_x;
   logic [44:0] projectiles_y;
   logic        collide, alive, fire_evt;
   int          checks = 0, failures = 0, t = 0;

   enemy_shooter #(.FIRE_PERIOD(4), .RESPAWN(8)) dut (
      .clk_4(clk_4), .clr(clr), .play(play), .enemy_x(enemy_x), .enemy_y(enemy_y),
      .destroy(destroy), .pproj_x(pproj_x), .pproj_y(pproj_y),
      .projectiles_x(projectiles_x), .projectiles_y(projectiles_y),
      .collide(collide), .alive(alive), .fire_evt(fire_evt)
   );

   always #5 clk_4 = ~clk_4;

   function automatic logic [8:0] sy(input int i);
      return projectiles_y[9*i +: 9];
   endfunction

   function automatic logic [9:0] sx(input int i);
      return (i == 4) ? projectiles_x[45:36] : {1'b0, projectiles_x[9*i +: 9]};
   endfunction

   task automatic tick;
      @(posedge clk_4);
      #1;
      t++;
   endtask

   task automatic run_to(input int tt);
      while (t < tt) tick();
   endtask

   task automatic do_reset;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      t = 0;
   endtask

   task automatic test_reset;
      do_reset();
      checks++; if (projectiles_y !== {5{9'd470}}) begin failures++; $display("FAIL reset_y got %h exp %h", projectiles_y, {5{9'd470}}); end
      checks++; if (projectiles_x !== 46'd0) begin failures++; $display("FAIL reset_x got %h exp 0", projectiles_x); end
      checks++; if (alive !== 1'b1) begin failures++; $display("FAIL reset_alive got %b exp 1", alive); end
      checks++; if (collide !== 1'b0 || fire_evt !== 1'b0) begin failures++; $display("FAIL reset_pulses got c=%b f=%b exp 0 0", collide, fire_evt); end
   endtask

   task automatic test_fire;
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++; if (fire_evt !== 1'b0) begin failures++; $display("FAIL fire_early t=%0d got %b exp 0", t, fire_evt); end
      end
      tick();
      checks++; if (fire_evt !== 1'b1) begin failures++; $display("FAIL fire_t4 got %b exp 1", fire_evt); end
      checks++; if (sy(0) !== 9'd112 || sx(0) !== 10'd300) begin failures++; $display("FAIL fire_slot0 got (%0d,%0d) exp (300,112)", sx(0), sy(0)); end
      tick();
      checks++; if (sy(0) !== 9'd113 || fire_evt !== 1'b0) begin failures++; $display("FAIL move_t5 got y=%0d f=%b exp 113 0", sy(0), fire_evt); end
      run_to(8);
      checks++; if (fire_evt !== 1'b1 || sy(1) !== 9'd112 || sy(0) !== 9'd116) begin failures++; $display("FAIL fire_t8 got f=%b y1=%0d y0=%0d exp 1 112 116", fire_evt, sy(1), sy(0)); end
   endtask

   task automatic test_retire_full;
      run_to(24);
      checks++; if (fire_evt !== 1'b0) begin failures++; $display("FAIL full_fire got %b exp 0", fire_evt); end
      checks++; if (sy(4) !== 9'd116 || sy(0) !== 9'd132) begin failures++; $display("FAIL full_slots got y4=%0d y0=%0d exp 116 132", sy(4), sy(0)); end
      run_to(351);
      checks++; if (sy(0) !== 9'd459) begin failures++; $display("FAIL pre_retire got %0d exp 459", sy(0)); end
      tick();
      checks++; if (sy(0) !== 9'd470 || sx(0) !== 10'd0) begin failures++; $display("FAIL retire got (%0d,%0d) exp (0,470)", sx(0), sy(0)); end
      checks++; if (fire_evt !== 1'b0) begin failures++; $display("FAIL retire_noreuse got %b exp 0", fire_evt); end
      run_to(356);
      checks++; if (fire_evt !== 1'b1 || sy(0) !== 9'd112 || sy(1) !== 9'd470) begin failures++; $display("FAIL refire got f=%b y0=%0d y1=%0d exp 1 112 470", fire_evt, sy(0), sy(1)); end
   endtask

   task automatic test_destroy;
      do_reset();
      run_to(12);
      destroy = 5'b10100;
      tick();
      destroy = 5'b0;
      checks++; if (sy(2) !== 9'd470 || sx(2) !== 10'd0) begin failures++; $display("FAIL destroy2 got (%0d,%0d) exp (0,470)", sx(2), sy(2)); end
      checks++; if (sy(0) !== 9'd121 || sy(1) !== 9'd117 || sy(4) !== 9'd470) begin failures++; $display("FAIL destroy_others got %0d %0d %0d exp 121 117 470", sy(0), sy(1), sy(4)); end
      run_to(16);
      checks++; if (fire_evt !== 1'b1 || sy(2) !== 9'd112) begin failures++; $display("FAIL relaunch2 got f=%b y2=%0d exp 1 112", fire_evt, sy(2)); end
      run_to(23);
      enemy_x = 10'd600;
      tick();
      checks++; if (sx(4) !== 10'd600 || sy(4) !== 9'd112 || sx(0) !== 10'd300) begin failures++; $display("FAIL slot4_x got x4=%0d y4=%0d x0=%0d exp 600 112 300", sx(4), sy(4), sx(0)); end
      run_to(27);
      destroy = 5'b00100;
      tick();
      destroy = 5'b0;
      checks++; if (fire_evt !== 1'b0 || sy(2) !== 9'd470) begin failures++; $display("FAIL destroy_fire got f=%b y2=%0d exp 0 470", fire_evt, sy(2)); end
      checks++; if (sy(3) !== 9'd120 || sy(4) !== 9'd116) begin failures++; $display("FAIL destroy_fire_others got %0d %0d exp 120 116", sy(3), sy(4)); end
      run_to(32);
      checks++; if (fire_evt !== 1'b1 || sy(2) !== 9'd112 || sx(2) !== 10'd88) begin failures++; $display("FAIL launch_t32 got f=%b (%0d,%0d) exp 1 (88,112)", fire_evt, sx(2), sy(2)); end
      enemy_x = 10'd300;
   endtask

   task automatic test_hit;
      do_reset();
      run_to(5);
      pproj_x = 10'd305; pproj_y = 10'd104;
      tick();
      checks++; if (collide !== 1'b1 || alive !== 1'b0) begin failures++; $display("FAIL hit got c=%b a=%b exp 1 0", collide, alive); end
      tick();
      checks++; if (collide !== 1'b0 || alive !== 1'b0) begin failures++; $display("FAIL hit_pulse got c=%b a=%b exp 0 0", collide, alive); end
      pproj_y = 10'd470;
      for (int k = 8; k <= 13; k++) begin
         tick();
         checks++; if (fire_evt !== 1'b0 || alive !== 1'b0 || collide !== 1'b0) begin failures++; $display("FAIL dead t=%0d got f=%b a=%b c=%b exp 0 0 0", t, fire_evt, alive, collide); end
      end
      tick();
      checks++; if (alive !== 1'b1 || fire_evt !== 1'b0 || sy(0) !== 9'd122) begin failures++; $display("FAIL respawn got a=%b f=%b y0=%0d exp 1 0 122", alive, fire_evt, sy(0)); end
      run_to(17);
      checks++; if (fire_evt !== 1'b0) begin failures++; $display("FAIL respawn_t17 got %b exp 0", fire_evt); end
      tick();
      checks++; if (fire_evt !== 1'b1 || sy(1) !== 9'd112) begin failures++; $display("FAIL respawn_fire got f=%b y1=%0d exp 1 112", fire_evt, sy(1)); end
   endtask

   task automatic test_boundary;
      do_reset();
      pproj_x = 10'd310; pproj_y = 10'd100; tick();
      checks++; if (collide !== 1'b0) begin failures++; $display("FAIL dx_p10 got %b exp 0", collide); end
      pproj_x = 10'd290; tick();
      checks++; if (collide !== 1'b0) begin failures++; $display("FAIL dx_m10 got %b exp 0", collide); end
      pproj_x = 10'd300; pproj_y = 10'd110; tick();
      checks++; if (collide !== 1'b0) begin failures++; $display("FAIL dy_p10 got %b exp 0", collide); end
      pproj_x = 10'd291; pproj_y = 10'd100; tick();
      checks++; if (collide !== 1'b1) begin failures++; $display("FAIL dx_m9 got %b exp 1", collide); end
      pproj_y = 10'd470;
      do_reset();
      pproj_x = 10'd309; pproj_y = 10'd109; tick();
      checks++; if (collide !== 1'b1) begin failures++; $display("FAIL dxdy_9 got %b exp 1", collide); end
      enemy_y = 10'd465;
      do_reset();
      pproj_x = 10'd300; pproj_y = 10'd470; tick();
      checks++; if (collide !== 1'b0) begin failures++; $display("FAIL parked_pproj got %b exp 0", collide); end
      pproj_y = 10'd469; tick();
      checks++; if (collide !== 1'b1) begin failures++; $display("FAIL pproj_469 got %b exp 1", collide); end
      pproj_y = 10'd470;
      enemy_y = 10'd100;
   endtask

   task automatic test_reset_mid;
      do_reset();
      run_to(12);
      pproj_x = 10'd305; pproj_y = 10'd104;
      tick();
      pproj_y = 10'd470;
      checks++; if (alive !== 1'b0) begin failures++; $display("FAIL mid_dead got %b exp 0", alive); end
      play = 1'b0;
      tick();
      play = 1'b1;
      t = 0;
      checks++; if (projectiles_y !== {5{9'd470}} || projectiles_x !== 46'd0) begin failures++; $display("FAIL mid_park got x=%h y=%h", projectiles_x, projectiles_y); end
      checks++; if (alive !== 1'b1 || collide !== 1'b0 || fire_evt !== 1'b0) begin failures++; $display("FAIL mid_state got a=%b c=%b f=%b exp 1 0 0", alive, collide, fire_evt); end
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++; if (fire_evt !== 1'b0) begin failures++; $display("FAIL mid_timer t=%0d got %b exp 0", t, fire_evt); end
      end
      tick();
      checks++; if (fire_evt !== 1'b1 || sy(0) !== 9'd112) begin failures++; $display("FAIL mid_refire got f=%b y0=%0d exp 1 112", fire_evt, sy(0)); end
   endtask

   initial begin
      test_reset();
      test_fire();
      test_retire_full();
      test_destroy();
      test_hit();
      test_boundary();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
